// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl
// Turns a stream of PS/2 set-2 scan-code bytes into key events
// {ext, brk, code}. The events are queued in a small FIFO for a
// ready/valid consumer.
//
// Ports
//   clk, resetn            system clock; synchronous active-low reset
//   byte_valid, byte_data  one-cycle strobe and byte from the PS/2 receiver
//   evt_valid, evt_ready   FIFO head handshake (read = valid & ready)
//   evt_code/brk/ext       head event fields (0 while empty or in reset)
//   evt_count              FIFO occupancy, 0..DEPTH
//   overflow, ovf_clr      sticky drop flag and its clear
//   make_cnt               wrapping count of accepted press events
//
// Decoder states
//   state      | meaning
//   S_IDLE     | no prefix pending
//   S_EXT      | E0 seen
//   S_BRK      | F0 seen
//   S_EXT_BRK  | both E0 and F0 seen
module ps2_key_ctrl #(
  parameter int unsigned DEPTH   = 8,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     byte_valid,
  input  logic [7:0]               byte_data,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [7:0]               evt_code,
  output logic                     evt_brk,
  output logic                     evt_ext,
  output logic [$clog2(DEPTH):0]   evt_count,
  output logic                     overflow,
  input  logic                     ovf_clr,
  output logic [7:0]               make_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] tmo_q, tmo_d;

  logic        emit;
  logic        emit_ext;
  logic        emit_brk;
  logic        err_byte;

  assign err_byte = (byte_data == 8'h00) || (byte_data == 8'hFF);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    emit     = 1'b0;
    emit_ext = 1'b0;
    emit_brk = 1'b0;
    if (byte_valid) begin
      tmo_d = '0;
      if (err_byte) begin
        state_d = S_IDLE;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (byte_data == 8'hE0)      state_d = S_EXT;
            else if (byte_data == 8'hF0) state_d = S_BRK;
            else                         emit    = 1'b1;
          end
          S_EXT: begin
            if (byte_data == 8'hF0) begin
              state_d = S_EXT_BRK;
            end else if (byte_data != 8'hE0) begin
              emit     = 1'b1;
              emit_ext = 1'b1;
              state_d  = S_IDLE;
            end
          end
          S_BRK: begin
            if (byte_data == 8'hE0) begin
              state_d = S_EXT_BRK;
            end else if (byte_data != 8'hF0) begin
              emit     = 1'b1;
              emit_brk = 1'b1;
              state_d  = S_IDLE;
            end
          end
          S_EXT_BRK: begin
            if ((byte_data != 8'hE0) && (byte_data != 8'hF0)) begin
              emit     = 1'b1;
              emit_ext = 1'b1;
              emit_brk = 1'b1;
              state_d  = S_IDLE;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end else if (state_q != S_IDLE) begin
      // A stalled prefix is abandoned once TIMEOUT idle cycles have elapsed.
      if (tmo_q >= TIMEOUT - 16'd1) begin
        state_d = S_IDLE;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + 16'd1;
      end
    end
  end

  // Event FIFO
  logic [9:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [7:0]    make_cnt_q;
  logic          ovf_q;

  logic          full;
  logic          rd_en;
  logic          wr_en;
  logic          drop;
  logic [9:0]    head;

  assign full  = (count_q == CW'(DEPTH));
  assign rd_en = evt_valid & evt_ready;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wr_en = emit & (~full | rd_en);
  assign drop  = emit & full & ~rd_en;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {emit_ext, emit_brk, byte_data};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      make_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (wr_en && !rd_en)      count_q <= count_q + CW'(1);
      else if (rd_en && !wr_en) count_q <= count_q - CW'(1);
      if (wr_en && !emit_brk) make_cnt_q <= make_cnt_q + 8'd1;
      if (drop)         ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  assign head      = mem_q[rd_ptr_q];
  // Gated with resetn so the head reads zero throughout reset.
  assign evt_valid = resetn & (count_q != '0);
  assign evt_code  = evt_valid ? head[7:0] : 8'h00;
  assign evt_brk   = evt_valid & head[8];
  assign evt_ext   = evt_valid & head[9];
  assign evt_count = count_q;
  assign overflow  = ovf_q;
  assign make_cnt  = make_cnt_q;

endmodule
